neurosync_seq_engine: RTL



---
 rtl/neurosync_pkg.sv | 29 ++
 rtl/neurosync_lfsr8.sv | 23 ++
 rtl/neurosync_seq_engine.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/neurosync_pkg.sv
// Shared types and constants for the neurosync sequence-game family:
// state encodings (exported on db_state) and the 8-bit LFSR definition.
package neurosync_pkg;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_LOAD       = 4'd1,
    S_SHOW_ON    = 4'd2,
    S_SHOW_OFF   = 4'd3,
    S_PLAY       = 4'd4,
    S_CHECK      = 4'd5,
    S_NEXT_ROUND = 4'd6,
    S_DONE       = 4'd7
  } state_t;

  // Feedback taps: bits 7, 5, 4 and 3.
  localparam logic [7:0] LFSR_TAPS     = 8'b1011_1000;
  localparam logic [7:0] SEED_ZERO_SUB = 8'h01;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

  // An all-zero seed would lock the LFSR, so it is swapped for a live one.
  function automatic logic [7:0] fix_seed(input logic [7:0] s);
    return (s == 8'h00) ? SEED_ZERO_SUB : s;
  endfunction

endpackage

// File: rtl/neurosync_lfsr8.sv
// 8-bit Fibonacci LFSR with synchronous load and step; load has priority.
module neurosync_lfsr8
  import neurosync_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic       step,
  input  logic [7:0] seed,
  output logic [7:0] state
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= SEED_ZERO_SUB;
    end else if (load) begin
      state <= seed;
    end else if (step) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/neurosync_seq_engine.sv
// Sequence-game core: shows an LFSR-derived LED sequence, then checks button
// presses against it (single-round or progressive mode) with a press timeout.
module neurosync_seq_engine
  import neurosync_pkg::*;
#(
  parameter  int N_CH           = 4,
  parameter  int MAX_LEN        = 16,
  parameter  int ON_CYCLES      = 4,
  parameter  int OFF_CYCLES     = 2,
  parameter  int TIMEOUT_CYCLES = 50,
  parameter  int SCORE_W        = 5,
  localparam int CH_W           = $clog2(N_CH),
  localparam int LEN_W          = $clog2(MAX_LEN + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [7:0]         seed,
  input  logic [LEN_W-1:0]   seq_len,
  input  logic [N_CH-1:0]    buttons,
  output logic [N_CH-1:0]    leds,
  output logic [SCORE_W-1:0] score,
  output logic               busy,
  output logic               done,
  output logic               win,
  output logic               timeout,
  output logic [3:0]         db_state
);

  localparam int TMR_MAX0 = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TMR_MAX  = (TMR_MAX0 > TIMEOUT_CYCLES) ? TMR_MAX0 : TIMEOUT_CYCLES;
  localparam int TMR_W    = $clog2(TMR_MAX + 1);

  state_t             state, next_state;
  logic [TMR_W-1:0]   tmr;
  logic [LEN_W-1:0]   idx, round, len_q, eff_len;
  logic [7:0]         seed_q, lfsr_q, lfsr_seed;
  logic               mode_q;
  logic [N_CH-1:0]    cap, btn_prev, target;
  logic [CH_W-1:0]    elem;
  logic               press_evt, last_elem;

  // FSM control strobes
  logic tmr_clr, idx_inc, idx_clr, lfsr_load, lfsr_step;
  logic score_inc, round_inc, take_start, set_win, set_to, cap_en;

  // Element idx is the low bits of the LFSR one step ahead of the stored state.
  assign elem      = CH_W'(lfsr_next(lfsr_q));
  assign target    = N_CH'(1) << elem;
  assign press_evt = (|buttons) & ~(|btn_prev);
  assign last_elem = (idx == round - LEN_W'(1));
  assign lfsr_seed = take_start ? fix_seed(seed) : seed_q;

  always_comb begin
    eff_len = seq_len;
    if (seq_len == '0) begin
      eff_len = LEN_W'(1);
    end else if (seq_len > LEN_W'(MAX_LEN)) begin
      eff_len = LEN_W'(MAX_LEN);
    end
  end

  neurosync_lfsr8 u_lfsr (
    .clock (clock),
    .reset (reset),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .seed  (lfsr_seed),
    .state (lfsr_q)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    tmr_clr    = 1'b0;
    idx_inc    = 1'b0;
    idx_clr    = 1'b0;
    lfsr_load  = 1'b0;
    lfsr_step  = 1'b0;
    score_inc  = 1'b0;
    round_inc  = 1'b0;
    take_start = 1'b0;
    set_win    = 1'b0;
    set_to     = 1'b0;
    cap_en     = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          take_start = 1'b1;
          lfsr_load  = 1'b1;
          next_state = S_LOAD;
        end
      end
      S_LOAD: begin
        tmr_clr    = 1'b1;
        next_state = S_SHOW_ON;
      end
      S_SHOW_ON: begin
        if (tmr == TMR_W'(ON_CYCLES - 1)) begin
          tmr_clr    = 1'b1;
          next_state = S_SHOW_OFF;
        end
      end
      S_SHOW_OFF: begin
        if (tmr == TMR_W'(OFF_CYCLES - 1)) begin
          tmr_clr = 1'b1;
          if (idx < round - LEN_W'(1)) begin
            idx_inc    = 1'b1;
            lfsr_step  = 1'b1;
            next_state = S_SHOW_ON;
          end else begin
            idx_clr    = 1'b1;
            lfsr_load  = 1'b1;
            next_state = S_PLAY;
          end
        end
      end
      S_PLAY: begin
        // A press landing on the expiry cycle still counts.
        if (press_evt) begin
          cap_en     = 1'b1;
          tmr_clr    = 1'b1;
          next_state = S_CHECK;
        end else if (tmr == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          set_to     = 1'b1;
          next_state = S_DONE;
        end
      end
      S_CHECK: begin
        tmr_clr = 1'b1;
        if (cap != target) begin
          next_state = S_DONE;
        end else begin
          score_inc = ~mode_q;
          if (last_elem) begin
            next_state = S_NEXT_ROUND;
          end else begin
            idx_inc    = 1'b1;
            lfsr_step  = 1'b1;
            next_state = S_PLAY;
          end
        end
      end
      S_NEXT_ROUND: begin
        score_inc = mode_q;
        if (!mode_q || round == len_q) begin
          set_win    = 1'b1;
          next_state = S_DONE;
        end else begin
          round_inc  = 1'b1;
          idx_clr    = 1'b1;
          lfsr_load  = 1'b1;
          tmr_clr    = 1'b1;
          next_state = S_SHOW_ON;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tmr      <= '0;
      idx      <= '0;
      round    <= '0;
      len_q    <= '0;
      seed_q   <= SEED_ZERO_SUB;
      mode_q   <= 1'b0;
      score    <= '0;
      cap      <= '0;
      btn_prev <= '0;
      win      <= 1'b0;
      timeout  <= 1'b0;
      leds     <= '0;
    end else begin
      // btn_prev always tracks buttons, so presses outside PLAY never arm an edge.
      btn_prev <= buttons;
      leds     <= (state == S_SHOW_ON) ? target : '0;
      tmr      <= tmr_clr ? '0 : tmr + 1'b1;
      if (cap_en) begin
        cap <= buttons;
      end
      if (take_start) begin
        mode_q  <= mode;
        seed_q  <= fix_seed(seed);
        len_q   <= eff_len;
        round   <= mode ? LEN_W'(1) : eff_len;
        idx     <= '0;
        score   <= '0;
        win     <= 1'b0;
        timeout <= 1'b0;
      end else begin
        if (idx_clr) begin
          idx <= '0;
        end else if (idx_inc) begin
          idx <= idx + 1'b1;
        end
        if (round_inc) begin
          round <= round + 1'b1;
        end
        if (score_inc && score != '1) begin
          score <= score + 1'b1;
        end
        if (set_win) begin
          win <= 1'b1;
        end
        if (set_to) begin
          timeout <= 1'b1;
        end
      end
    end
  end

  assign busy     = (state != S_IDLE) && (state != S_DONE);
  assign done     = (state == S_DONE);
  assign db_state = state;

endmodule
